// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data-side memory responder.
package data_mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } mem_resp_state_t;

    localparam int unsigned DMEM_WORD_BYTES = 4;

    // Misaligned or beyond the end of the memory window (offset is addr - base, unsigned)
    function automatic logic dmem_addr_err(input logic [1:0]  addr_lsbs,
                                           input logic [31:0] offset,
                                           input logic [31:0] span);
        return (addr_lsbs != 2'b00) || (offset >= span);
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// LSU <-> data memory request/grant bus; master is the LSU, slave is the responder.
interface data_mem_responder_if;
    logic        data_req_ip;
    logic        data_we_ip;
    logic [31:0] data_addr_ip;
    logic [31:0] data_wdata_ip;
    logic        data_gnt_op;
    logic        data_rvalid_op;
    logic [31:0] data_rdata_op;
    logic        data_err_op;

    modport master (
        output data_req_ip, data_we_ip, data_addr_ip, data_wdata_ip,
        input  data_gnt_op, data_rvalid_op, data_rdata_op, data_err_op
    );

    modport slave (
        input  data_req_ip, data_we_ip, data_addr_ip, data_wdata_ip,
        output data_gnt_op, data_rvalid_op, data_rdata_op, data_err_op
    );
endinterface

// File: rtl/dmem_ram.sv
// Single-port word RAM with registered read data; no reset on contents or output.
// Latency: read data one edge after addr; no backpressure.
module dmem_ram #(
    parameter  int unsigned DEPTH_WORDS = 256,
    localparam int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clock,
    input  logic             we,
    input  logic [IDX_W-1:0] addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/data_mem_responder.sv
// Word-addressed data memory answering LSU load/store requests with a data or error response.
// Latency: response READ_LATENCY cycles after acceptance; one request in flight, grant low until done.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS  = 256,
    parameter int unsigned READ_LATENCY = 2,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
    input logic                 clock,
    input logic                 reset,
    data_mem_responder_if.slave bus
);

    localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN     = 32'(DEPTH_WORDS * DMEM_WORD_BYTES);
    localparam logic [3:0]  CNT_INIT = (READ_LATENCY > 1) ? 4'(READ_LATENCY - 2) : 4'd0;

    mem_resp_state_t  state, next_state;
    logic [3:0]       cnt;
    logic             gnt_q;
    logic             we_q;
    logic             err_q;
    logic [IDX_W-1:0] idx_q;

    logic             accept;
    logic [31:0]      offset;
    logic             req_err;
    logic [IDX_W-1:0] req_idx;
    logic             ram_we;
    logic [IDX_W-1:0] ram_addr;
    logic [31:0]      ram_rdata;

    assign accept  = bus.data_req_ip & gnt_q;
    assign offset  = bus.data_addr_ip - BASE_ADDR;
    assign req_err = dmem_addr_err(bus.data_addr_ip[1:0], offset, SPAN);
    assign req_idx = IDX_W'(offset >> 2);

    // The RAM keeps re-reading the latched index after acceptance, so its output
    // register acts as the load-data latch until the response is issued.
    assign ram_we   = accept & bus.data_we_ip & ~req_err;
    assign ram_addr = accept ? req_idx : idx_q;

    dmem_ram #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_ram (
        .clock (clock),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (bus.data_wdata_ip),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = (READ_LATENCY > 1) ? WAIT : RESP;
            WAIT:    if (cnt == 4'd0) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt   <= 4'd0;
            gnt_q <= 1'b0;
            we_q  <= 1'b0;
            err_q <= 1'b0;
            idx_q <= '0;
        end else begin
            // Grant is a registered decode of the next state: no req -> gnt path.
            gnt_q <= (next_state == IDLE);
            if (accept) begin
                we_q  <= bus.data_we_ip;
                err_q <= req_err;
                idx_q <= req_idx;
                cnt   <= CNT_INIT;
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    assign bus.data_gnt_op    = gnt_q;
    assign bus.data_rvalid_op = (state == RESP);
    assign bus.data_err_op    = (state == RESP) & err_q;
    assign bus.data_rdata_op  = ((state == RESP) && !we_q && !err_q) ? ram_rdata : 32'h0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: READ_LATENCY=2 instance for functional/reset cases, READ_LATENCY=1 for back-to-back.
module tb_data_mem_responder;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    exp_t q_a[$];
    exp_t q_b[$];

    data_mem_responder_if bus_a ();
    data_mem_responder_if bus_b ();

    data_mem_responder #(.DEPTH_WORDS(256), .READ_LATENCY(2), .BASE_ADDR(32'h0)) dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    data_mem_responder #(.DEPTH_WORDS(256), .READ_LATENCY(1), .BASE_ADDR(32'h0)) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc = cyc + 1;

    // Response monitor / scoreboard for the READ_LATENCY=2 instance
    always @(negedge clock) begin
        exp_t e;
        if (bus_a.data_rvalid_op === 1'b1) begin
            checks++;
            assert (q_a.size() > 0) else begin
                failures++; $error("FAIL a_unexpected_rvalid observed=1 expected=0");
            end
            if (q_a.size() > 0) begin
                e = q_a.pop_front();
                checks++;
                assert (bus_a.data_err_op === e.err) else begin
                    failures++; $error("FAIL a_err observed=%b expected=%b", bus_a.data_err_op, e.err);
                end
                checks++;
                assert (bus_a.data_rdata_op === e.rdata) else begin
                    failures++; $error("FAIL a_rdata observed=%h expected=%h", bus_a.data_rdata_op, e.rdata);
                end
                checks++;
                assert (cyc - e.cyc === 2) else begin
                    failures++; $error("FAIL a_latency observed=%0d expected=2", cyc - e.cyc);
                end
                checks++;
                assert (bus_a.data_gnt_op === 1'b0) else begin
                    failures++; $error("FAIL a_gnt_in_resp observed=%b expected=0", bus_a.data_gnt_op);
                end
            end
        end else begin
            checks++;
            assert ({bus_a.data_rvalid_op, bus_a.data_err_op, bus_a.data_rdata_op} === 34'h0) else begin
                failures++; $error("FAIL a_idle_outputs observed=%b/%b/%h expected=0/0/0",
                                   bus_a.data_rvalid_op, bus_a.data_err_op, bus_a.data_rdata_op);
            end
        end
    end

    // Response monitor / scoreboard for the READ_LATENCY=1 instance
    always @(negedge clock) begin
        exp_t e;
        if (bus_b.data_rvalid_op === 1'b1) begin
            checks++;
            assert (q_b.size() > 0) else begin
                failures++; $error("FAIL b_unexpected_rvalid observed=1 expected=0");
            end
            if (q_b.size() > 0) begin
                e = q_b.pop_front();
                checks++;
                assert ({bus_b.data_err_op, bus_b.data_rdata_op} === {e.err, e.rdata}) else begin
                    failures++; $error("FAIL b_resp observed=%b/%h expected=%b/%h",
                                       bus_b.data_err_op, bus_b.data_rdata_op, e.err, e.rdata);
                end
                checks++;
                assert (cyc - e.cyc === 1) else begin
                    failures++; $error("FAIL b_latency observed=%0d expected=1", cyc - e.cyc);
                end
            end
        end
    end

    // Issue one request on bus_a once granted; expectation is queued as it is driven.
    task automatic req_a(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err);
        int n = 0;
        while (bus_a.data_gnt_op !== 1'b1 && n < 20) begin
            @(posedge clock); #1; n++;
        end
        checks++;
        assert (bus_a.data_gnt_op === 1'b1) else begin
            failures++; $error("FAIL a_gnt_wait observed=%b expected=1", bus_a.data_gnt_op);
        end
        bus_a.data_req_ip   = 1'b1;
        bus_a.data_we_ip    = we;
        bus_a.data_addr_ip  = addr;
        bus_a.data_wdata_ip = wd;
        q_a.push_back('{exp_err, exp_rd, cyc});
        @(posedge clock); #1;
        bus_a.data_req_ip = 1'b0;
        checks++;
        assert (bus_a.data_gnt_op === 1'b0) else begin
            failures++; $error("FAIL a_gnt_after_accept observed=%b expected=0", bus_a.data_gnt_op);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && n < 30) begin
            @(posedge clock); #1; n++;
        end
        checks++;
        assert (q_a.size() + q_b.size() === 0) else begin
            failures++; $error("FAIL drain_timeout observed=%0d expected=0", q_a.size() + q_b.size());
        end
    endtask

    initial begin
        reset = 1'b1;
        bus_a.data_req_ip = 1'b0; bus_a.data_we_ip = 1'b0;
        bus_a.data_addr_ip = 32'h0; bus_a.data_wdata_ip = 32'h0;
        bus_b.data_req_ip = 1'b0; bus_b.data_we_ip = 1'b0;
        bus_b.data_addr_ip = 32'h0; bus_b.data_wdata_ip = 32'h0;

        repeat (3) @(posedge clock);
        #1;
        checks++;
        assert ({bus_a.data_gnt_op, bus_b.data_gnt_op} === 2'b00) else begin
            failures++; $error("FAIL reset_gnt observed=%b%b expected=00", bus_a.data_gnt_op, bus_b.data_gnt_op);
        end
        reset = 1'b0;
        @(negedge clock);
        checks++;
        assert (bus_a.data_gnt_op === 1'b0) else begin
            failures++; $error("FAIL gnt_before_edge observed=%b expected=0", bus_a.data_gnt_op);
        end
        @(posedge clock); #1;
        checks++;
        assert ({bus_a.data_gnt_op, bus_b.data_gnt_op} === 2'b11) else begin
            failures++; $error("FAIL gnt_after_reset observed=%b%b expected=11", bus_a.data_gnt_op, bus_b.data_gnt_op);
        end

        // Store/load, misaligned, out-of-range and last-word accesses
        req_a(1'b1, 32'h10,  32'hDEAD_BEEF, 32'h0,         1'b0);
        req_a(1'b0, 32'h10,  32'h0,         32'hDEAD_BEEF, 1'b0);
        req_a(1'b0, 32'h13,  32'h0,         32'h0,         1'b1);
        req_a(1'b1, 32'h11,  32'h1234_5678, 32'h0,         1'b1);
        req_a(1'b0, 32'h10,  32'h0,         32'hDEAD_BEEF, 1'b0);
        req_a(1'b0, 32'h400, 32'h0,         32'h0,         1'b1);
        req_a(1'b1, 32'h3FC, 32'h0BAD_CAFE, 32'h0,         1'b0);
        req_a(1'b0, 32'h3FC, 32'h0,         32'h0BAD_CAFE, 1'b0);
        drain();

        // Request held high on the latency-1 instance: grant alternates, one response per acceptance
        bus_b.data_req_ip   = 1'b1;
        bus_b.data_we_ip    = 1'b1;
        bus_b.data_addr_ip  = 32'h20;
        bus_b.data_wdata_ip = 32'hCAFE_F00D;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            checks++;
            assert (bus_b.data_gnt_op === ((i % 2) == 0)) else begin
                failures++; $error("FAIL b_gnt_pattern step=%0d observed=%b expected=%b",
                                   i, bus_b.data_gnt_op, ((i % 2) == 0));
            end
            if (bus_b.data_gnt_op === 1'b1)
                q_b.push_back('{1'b0, (bus_b.data_we_ip ? 32'h0 : 32'hCAFE_F00D), cyc});
            @(posedge clock); #1;
            if (i == 3) bus_b.data_we_ip = 1'b0;
        end
        bus_b.data_req_ip = 1'b0;
        drain();

        // Reset while bus_a sits in WAIT: the pending load must never respond
        checks++;
        assert (bus_a.data_gnt_op === 1'b1) else begin
            failures++; $error("FAIL a_gnt_before_abort observed=%b expected=1", bus_a.data_gnt_op);
        end
        bus_a.data_req_ip  = 1'b1;
        bus_a.data_we_ip   = 1'b0;
        bus_a.data_addr_ip = 32'h10;
        @(posedge clock); #1;
        bus_a.data_req_ip = 1'b0;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        checks++;
        assert (bus_a.data_gnt_op === 1'b0) else begin
            failures++; $error("FAIL a_gnt_at_reset_release observed=%b expected=0", bus_a.data_gnt_op);
        end
        @(posedge clock); #1;
        checks++;
        assert (bus_a.data_gnt_op === 1'b1) else begin
            failures++; $error("FAIL a_gnt_after_abort observed=%b expected=1", bus_a.data_gnt_op);
        end
        repeat (3) @(posedge clock);
        #1;

        // Memory contents survive reset
        req_a(1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Word-addressed data memory that sits on the far side of the LSU's request/grant interface and services its load-word and store-word requests. Advertises readiness with a grant, accepts one request per handshake, commits stores, returns load data after a fixed latency, and flags misaligned or out-of-range accesses with an error response. Used as the data-side memory in core simulation and as the reference responder for LSU verification.

## Interface
Parameters:
- DEPTH_WORDS, 256: number of 32-bit words; power of two, at least 4.
- READ_LATENCY, 2: cycles from request acceptance to response; at least 1, at most 15.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; aligned to DEPTH_WORDS*4.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- data_req_ip  in  1  request valid from the LSU.
- data_we_ip  in  1  1 = store word, 0 = load word.
- data_addr_ip  in  32  byte address.
- data_wdata_ip  in  32  store data.
- data_gnt_op  out  1  responder ready; a request is accepted on an edge where data_req_ip & data_gnt_op.
- data_rvalid_op  out  1  one-cycle response strobe.
- data_rdata_op  out  32  load data; valid only with data_rvalid_op.
- data_err_op  out  1  error flag; valid only with data_rvalid_op.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: data_gnt_op = 1. On acceptance, latch we and the error decision, then go to WAIT if READ_LATENCY > 1, else to RESP. Without a request, stay in IDLE.
- Error decision at acceptance: err = (data_addr_ip[1:0] != 2'b00) | (data_addr_ip - BASE_ADDR >= DEPTH_WORDS*4), using 32-bit unsigned arithmetic. The word index is (data_addr_ip - BASE_ADDR)[clog2(DEPTH_WORDS)+1:2].
- Stores: when not in error, the RAM write commits at the acceptance edge. An erroring store writes nothing.
- Loads: when not in error, RAM data for the index is captured into the response register at the acceptance edge. A store followed by a load to the same word returns the new data.
- WAIT: data_gnt_op = 0. A 4-bit counter loads READ_LATENCY-2 at acceptance and decrements each cycle. Go to RESP when it reaches 0.
- RESP: data_gnt_op = 0 and data_rvalid_op = 1 for exactly one cycle, then go to IDLE.
  - data_err_op = latched err.
  - data_rdata_op = load data for a good load, otherwise 32'h0. Stores get an acknowledge with rdata 0.
- Outside RESP: data_rvalid_op, data_err_op and data_rdata_op are 0.
- data_req_ip is ignored while data_gnt_op = 0. There is no queuing.

## Timing
- Reset values:
  - data_gnt_op = 0, data_rvalid_op = 0, data_err_op = 0, data_rdata_op = 0.
  - State IDLE, counter 0. RAM contents are not cleared.
- data_gnt_op is 1 from the first cycle after reset deasserts.
- data_gnt_op is a registered state decode with no combinational path from data_req_ip. The LSU may therefore gate its request with it.
- Acceptance at edge E: data_rvalid_op is high in the cycle after edge E+READ_LATENCY-1. This is READ_LATENCY cycles after the acceptance cycle.
- Grant returns in the cycle after the response. Peak throughput is one request per READ_LATENCY+1 cycles.
- Reset during WAIT or RESP aborts the transaction: no response is issued, and a store already committed at acceptance remains.
- A request held high across the response is accepted again in the next IDLE cycle. The LSU is responsible for dropping req.

## Structure
- Add to CORE_PKG:
  - mem_resp_state_t enum {IDLE, WAIT, RESP}.
  - Constant DMEM_WORD_BYTES = 4.
- Sub-module dmem_ram: single-port synchronous RAM with parameter DEPTH_WORDS.
  - Ports: clock, we, addr index, wdata, rdata (read-before-write is not used; the responder never reads and writes in the same cycle).
  - No reset.
  - Because dmem_ram reads synchronously, load data appears one edge after the index is presented, so the top level must register the index at acceptance. This preserves the "captured at the acceptance edge" semantics.
- Top level holds the FSM, the counter, and the latched we/err/rdata registers.

## Test plan
- Reset, then idle: data_gnt_op goes 0 → 1 one cycle after reset deasserts; rvalid stays 0.
- Store 32'hDEAD_BEEF to 32'h10, then load 32'h10 (READ_LATENCY=2): store acknowledged (rvalid, err 0, rdata 0); load rvalid exactly 2 cycles after acceptance with rdata 32'hDEAD_BEEF; gnt low throughout WAIT/RESP.
- Misaligned load at 32'h13 and misaligned store of 32'h1234_5678 to 32'h11: both get rvalid with err 1 and rdata 0; a subsequent load of 32'h10 still returns the prior value.
- Out-of-range load at 32'h400 (DEPTH_WORDS=256): err 1. Load at 32'h3FC: err 0.
- Back-to-back requests with req held high, READ_LATENCY=1: accepted every 2 cycles, one rvalid per acceptance. Assert reset during a WAIT: no rvalid, and gnt returns the cycle after reset deasserts.
